// File: rtl/oled_glyph_streamer.sv
// oled_glyph_streamer: frames one font-ROM glyph as page/column commands plus its column bytes.
// Optional feature macro OLED_GLYPH_INVERT_EN adds an 'invert' input that complements data bytes.
module oled_glyph_streamer (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] glyph,
  input  logic       wide,
  input  logic [2:0] page,
  input  logic [6:0] col,
`ifdef OLED_GLYPH_INVERT_EN
  input  logic       invert,
`endif
  output logic       busy,
  output logic       done,
  output logic [5:0] font_sel,
  output logic       font_row,
  output logic [8:0] index,
  input  logic [7:0] font_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_dc,
  output logic [7:0] out_data
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_PAGE,
    CMD_LO,
    CMD_HI,
    FETCH,
    WAIT,
    SEND,
    DONE
  } state_t;

  state_t     state;
  logic       wide_q;
  logic [2:0] page_q;
  logic [6:0] col_q;
  logic [8:0] last_index;
  logic       at_last;
  logic [7:0] data_byte;

  assign last_index = wide_q ? 9'd15 : 9'd7;
  assign at_last    = (index == last_index);

`ifdef OLED_GLYPH_INVERT_EN
  logic inv_q;
  assign data_byte = font_data ^ {8{inv_q}};
`else
  assign data_byte = font_data;
`endif

  // font_row doubles as the glyph half counter; it is already stable for the FETCH address cycle.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wide_q    <= 1'b0;
      page_q    <= 3'd0;
      col_q     <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      font_sel  <= 6'd0;
      font_row  <= 1'b0;
      index     <= 9'd0;
      out_valid <= 1'b0;
      out_dc    <= 1'b0;
      out_data  <= 8'd0;
`ifdef OLED_GLYPH_INVERT_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            wide_q    <= wide;
            page_q    <= page;
            col_q     <= col;
            font_sel  <= glyph;
            font_row  <= 1'b0;
            index     <= 9'd0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_dc    <= 1'b0;
            out_data  <= {5'b10110, page};
`ifdef OLED_GLYPH_INVERT_EN
            inv_q     <= invert;
`endif
            state     <= CMD_PAGE;
          end
        end
        CMD_PAGE: begin
          if (out_ready) begin
            out_data <= {4'h0, col_q[3:0]};
            state    <= CMD_LO;
          end
        end
        CMD_LO: begin
          if (out_ready) begin
            out_data <= {5'b00010, col_q[6:4]};
            state    <= CMD_HI;
          end
        end
        CMD_HI: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= FETCH;
          end
        end
        FETCH: begin
          state <= WAIT;
        end
        // The ROM byte for the FETCH address is valid now; capture it so later ROM activity cannot disturb it.
        WAIT: begin
          out_valid <= 1'b1;
          out_dc    <= 1'b1;
          out_data  <= data_byte;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            if (at_last && !font_row) begin
              font_row <= 1'b1;
              index    <= 9'd0;
              out_dc   <= 1'b0;
              out_data <= {5'b10110, 3'(page_q + 3'd1)};
              state    <= CMD_PAGE;
            end else if (at_last) begin
              out_valid <= 1'b0;
              out_dc    <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              index     <= index + 9'd1;
              out_valid <= 1'b0;
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_glyph_streamer.sv
// tb_oled_glyph_streamer: directed tests of oled_glyph_streamer against a bench-side registered font ROM.
// Define OLED_GLYPH_INVERT_EN for both bench and RTL to exercise the inverted-data test.
module tb_oled_glyph_streamer;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] glyph;
  logic       wide;
  logic [2:0] page;
  logic [6:0] col;
`ifdef OLED_GLYPH_INVERT_EN
  logic       invert;
`endif
  logic       busy;
  logic       done;
  logic [5:0] font_sel;
  logic       font_row;
  logic [8:0] index;
  logic [7:0] font_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_dc;
  logic [7:0] out_data;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int done_count = 0;
  int done_cyc = 0;
  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  oled_glyph_streamer dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (start),
    .glyph     (glyph),
    .wide      (wide),
    .page      (page),
    .col       (col),
`ifdef OLED_GLYPH_INVERT_EN
    .invert    (invert),
`endif
    .busy      (busy),
    .done      (done),
    .font_sel  (font_sel),
    .font_row  (font_row),
    .index     (index),
    .font_data (font_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dc    (out_dc),
    .out_data  (out_data)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Font ROM contents: glyphs 12, 10 and the head of 3 are fixed bitmaps, everything else is a hash.
  function automatic logic [7:0] rom_byte(input logic [5:0] s, input logic r, input logic [8:0] i);
    logic [63:0] t;
    logic [7:0]  v;
    int k;
    k = int'(i);
    v = 8'(int'(s) * 7 + k * 13 + (r ? 101 : 0)) ^ 8'h3C;
    if (s == 6'd12 && k < 8) begin
      t = r ? 64'h203F2000030C3020 : 64'h08F8888888887000;
      v = t[8*(7-k) +: 8];
    end else if (s == 6'd10 && k < 8) begin
      t = r ? 64'h0030300000000000 : 64'h0000000000000000;
      v = t[8*(7-k) +: 8];
    end else if (s == 6'd3 && k < 4) begin
      t = r ? 64'h0808090900000000 : 64'h0008884800000000;
      v = t[8*(7-k) +: 8];
    end
    return v;
  endfunction

  always @(posedge sys_clk) font_data <= rom_byte(font_sel, font_row, index);

  always @(negedge sys_clk) begin
    if (out_valid && out_ready) got.push_back({out_dc, out_data});
    if (done) begin
      done_count++;
      done_cyc = cyc - t0 + 1;
    end
  end

  task automatic build_expected(input logic [5:0] g, input logic w, input logic [2:0] p,
                                input logic [6:0] c, input logic inv);
    logic [7:0] b;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({1'b0, 5'b10110, 3'(p + 3'(r))});
      exp_q.push_back({1'b0, 4'h0, c[3:0]});
      exp_q.push_back({1'b0, 5'b00010, c[6:4]});
      for (int k = 0; k < (w ? 16 : 8); k++) begin
        b = rom_byte(g, r[0], 9'(k)) ^ {8{inv}};
        exp_q.push_back({1'b1, b});
      end
    end
  endtask

  task automatic apply_start(input logic [5:0] g, input logic w, input logic [2:0] p,
                             input logic [6:0] c, input logic inv);
    @(posedge sys_clk);
    #1;
    glyph = g;
    wide  = w;
    page  = p;
    col   = c;
`ifdef OLED_GLYPH_INVERT_EN
    invert = inv;
`else
    if (inv) $display("[TB] invert requested without invert support");
`endif
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int base, input int budget, output bit hit);
    for (int n = 0; n < budget && done_count == base; n++) @(negedge sys_clk);
    hit = (done_count > base);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    glyph = 6'd0;
    wide = 1'b0;
    page = 3'd0;
    col = 7'd0;
    out_ready = 1'b1;
`ifdef OLED_GLYPH_INVERT_EN
    invert = 1'b0;
`endif
    repeat (3) @(negedge sys_clk);
    checks += 8;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_dc !== 1'b0) begin fails++; $display("[TB] FAIL reset_dc: got %b expected 0", out_dc); end
    if (out_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", out_data); end
    if (font_sel !== 6'd0) begin fails++; $display("[TB] FAIL reset_font_sel: got %h expected 00", font_sel); end
    if (font_row !== 1'b0) begin fails++; $display("[TB] FAIL reset_font_row: got %b expected 0", font_row); end
    if (index !== 9'd0) begin fails++; $display("[TB] FAIL reset_index: got %h expected 000", index); end
    rst = 1'b0;
  endtask

  task automatic test_narrow();
    int base;
    bit hit;
    logic [8:0] obs;
    got.delete();
    build_expected(6'd12, 1'b0, 3'd2, 7'd40, 1'b0);
    base = done_count;
    apply_start(6'd12, 1'b0, 3'd2, 7'd40, 1'b0);
    @(negedge sys_clk);
    checks += 3;
    if (busy !== 1'b1) begin fails++; $display("[TB] FAIL narrow_busy_first: got %b expected 1", busy); end
    if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL narrow_valid_first: got %b expected 1", out_valid); end
    if ({out_dc, out_data} !== 9'h0B2) begin fails++; $display("[TB] FAIL narrow_first_byte: got %h expected 0b2", {out_dc, out_data}); end
    wait_done(base, 300, hit);
    checks += 4;
    if (!hit) begin fails++; $display("[TB] FAIL narrow_done_timeout: got no done expected done"); end
    if (done_cyc !== 55) begin fails++; $display("[TB] FAIL narrow_done_cycle: got %0d expected 55", done_cyc); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL narrow_busy_at_done: got %b expected 0", busy); end
    if (got.size() !== 22) begin fails++; $display("[TB] FAIL narrow_count: got %0d expected 22", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size()) obs = got[i];
      checks++;
      if (obs !== exp_q[i]) begin fails++; $display("[TB] FAIL narrow_byte%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask

  task automatic test_wide();
    int base;
    bit hit;
    logic [8:0] obs;
    got.delete();
    build_expected(6'd3, 1'b1, 3'd7, 7'd0, 1'b0);
    base = done_count;
    apply_start(6'd3, 1'b1, 3'd7, 7'd0, 1'b0);
    wait_done(base, 400, hit);
    checks += 3;
    if (!hit) begin fails++; $display("[TB] FAIL wide_done_timeout: got no done expected done"); end
    if (done_cyc !== 103) begin fails++; $display("[TB] FAIL wide_done_cycle: got %0d expected 103", done_cyc); end
    if (got.size() !== 38) begin fails++; $display("[TB] FAIL wide_count: got %0d expected 38", got.size()); end
    obs = 'x;
    if (got.size() > 19) obs = got[19];
    checks++;
    if (obs !== 9'h0B0) begin fails++; $display("[TB] FAIL wide_page_wrap: got %h expected 0b0", obs); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size()) obs = got[i];
      checks++;
      if (obs !== exp_q[i]) begin fails++; $display("[TB] FAIL wide_byte%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    bit hit;
    bit stalled;
    logic [8:0] held;
    logic [8:0] obs;
    got.delete();
    build_expected(6'd13, 1'b0, 3'd4, 7'd100, 1'b0);
    base = done_count;
    stalled = 1'b0;
    held = '0;
    apply_start(6'd13, 1'b0, 3'd4, 7'd100, 1'b0);
    for (int k = 0; k < 400 && done_count == base; k++) begin
      @(posedge sys_clk);
      #1;
      out_ready = (k % 3 == 0);
      @(negedge sys_clk);
      if (stalled) begin
        checks++;
        if ({out_valid, out_dc, out_data} !== {1'b1, held}) begin
          fails++;
          $display("[TB] FAIL stall_hold: got %h expected %h", {out_valid, out_dc, out_data}, {1'b1, held});
        end
      end
      stalled = out_valid && !out_ready;
      held = {out_dc, out_data};
    end
    hit = (done_count > base);
    out_ready = 1'b1;
    checks += 2;
    if (!hit) begin fails++; $display("[TB] FAIL bp_done_timeout: got no done expected done"); end
    if (got.size() !== 22) begin fails++; $display("[TB] FAIL bp_count: got %0d expected 22", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size()) obs = got[i];
      checks++;
      if (obs !== exp_q[i]) begin fails++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int base;
    bit hit;
    logic [8:0] obs;
    got.delete();
    build_expected(6'd12, 1'b0, 3'd2, 7'd40, 1'b0);
    base = done_count;
    apply_start(6'd12, 1'b0, 3'd2, 7'd40, 1'b0);
    repeat (9) @(posedge sys_clk);
    #1;
    glyph = 6'd5;
    page = 3'd0;
    col = 7'd1;
    start = 1'b1;
    @(posedge sys_clk);
    #1;
    start = 1'b0;
    wait_done(base, 300, hit);
    repeat (120) @(negedge sys_clk);
    checks += 3;
    if (!hit) begin fails++; $display("[TB] FAIL ign_done_timeout: got no done expected done"); end
    if (done_count !== base + 1) begin fails++; $display("[TB] FAIL ign_done_count: got %0d expected %0d", done_count - base, 1); end
    if (got.size() !== 22) begin fails++; $display("[TB] FAIL ign_count: got %0d expected 22", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size()) obs = got[i];
      checks++;
      if (obs !== exp_q[i]) begin fails++; $display("[TB] FAIL ign_byte%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    int ndata;
    bit hit;
    logic [8:0] obs;
    got.delete();
    base = done_count;
    ndata = 0;
    apply_start(6'd12, 1'b0, 3'd2, 7'd40, 1'b0);
    for (int n = 0; n < 300 && ndata < 5; n++) begin
      @(negedge sys_clk);
      ndata = 0;
      foreach (got[i]) if (got[i][8]) ndata++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks += 4;
    if (ndata !== 5) begin fails++; $display("[TB] FAIL mid_reach_byte5: got %0d expected 5", ndata); end
    if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL mid_valid: got %b expected 0", out_valid); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy: got %b expected 0", busy); end
    if (index !== 9'd0) begin fails++; $display("[TB] FAIL mid_index: got %h expected 000", index); end
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if (done_count !== base) begin fails++; $display("[TB] FAIL mid_no_done: got %0d expected %0d", done_count, base); end
    got.delete();
    build_expected(6'd13, 1'b0, 3'd6, 7'd3, 1'b0);
    apply_start(6'd13, 1'b0, 3'd6, 7'd3, 1'b0);
    wait_done(base, 300, hit);
    checks += 2;
    if (!hit) begin fails++; $display("[TB] FAIL mid_restart_timeout: got no done expected done"); end
    if (got.size() !== 22) begin fails++; $display("[TB] FAIL mid_restart_count: got %0d expected 22", got.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size()) obs = got[i];
      checks++;
      if (obs !== exp_q[i]) begin fails++; $display("[TB] FAIL mid_byte%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask

`ifdef OLED_GLYPH_INVERT_EN
  task automatic test_invert();
    int base;
    bit hit;
    logic [8:0] obs;
    got.delete();
    build_expected(6'd10, 1'b0, 3'd1, 7'd0, 1'b1);
    base = done_count;
    apply_start(6'd10, 1'b0, 3'd1, 7'd0, 1'b1);
    wait_done(base, 300, hit);
    checks += 2;
    if (!hit) begin fails++; $display("[TB] FAIL inv_done_timeout: got no done expected done"); end
    obs = 'x;
    if (got.size() > 15) obs = got[15];
    if (obs !== 9'h1CF) begin fails++; $display("[TB] FAIL inv_row1_byte1: got %h expected 1cf", obs); end
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = 'x;
      if (i < got.size()) obs = got[i];
      checks++;
      if (obs !== exp_q[i]) begin fails++; $display("[TB] FAIL inv_byte%0d: got %h expected %h", i, obs, exp_q[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
`ifdef OLED_GLYPH_INVERT_EN
    test_invert();
`endif
    repeat (2) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
